// File: rtl/alu_pkg.sv
// Shared types and constants for the alu command sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

    // Shortest pipeline the alu can be built with; LAT below this cannot capture a valid result.
    localparam int ALU_MIN_LAT = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_CMP = 2'd2,
        OP_CLR = 2'd3
    } alu_op_t;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_lat_counter.sv
// Loadable down-counter that flags the final cycle of the alu wait window.
// Latency: last is high during the LAT-th cycle after the load edge.
// Backpressure: none; counts whenever dec is high and the count is non-zero.
module alu_sequencer_lat_counter
    import alu_pkg::*;
#(
    parameter int LAT = ALU_MIN_LAT,
    parameter int CW  = $clog2(LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [CW-1:0] cnt;

    // Load with LAT when the issue cycle ends, then count down once per wait cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LAT);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign last = (cnt == CW'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Drives one alu instance from a valid/ready request port and returns its result on a valid/ready response port.
// Latency: rsp_valid rises LAT+1 edges after the accept edge; one op per LAT+3 cycles.
// Backpressure: req_ready only in IDLE (no queueing); response held stable in RESP until rsp_ready.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy,
    output logic             alu_rst,
    output logic             alu_sum,
    output logic             alu_sub,
    output logic             alu_fi,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero
);

    seq_state_t state;
    alu_op_t    op_q;
    alu_op_t    req_op_e;
    logic       wait_last;

    assign req_op_e = alu_op_t'(req_op);

    alu_sequencer_lat_counter #(
        .LAT(LAT)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_ISSUE),
        .dec  (state == S_WAIT),
        .last (wait_last)
    );

    // Sequencer FSM; every output is a flop so nothing on the ports reaches an output combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            op_q      <= OP_ADD;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_op    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            busy      <= 1'b1;
            alu_rst   <= 1'b1;
            alu_sum   <= 1'b0;
            alu_sub   <= 1'b0;
            alu_fi    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            case (state)
                // alu_rst has been high for this cycle, which clears the alu.
                S_INIT: begin
                    state     <= S_IDLE;
                    alu_rst   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                // Strobes for the issue cycle are decoded here so they come straight from flops.
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_ISSUE;
                        op_q      <= req_op_e;
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        alu_sum   <= (req_op_e == OP_ADD);
                        alu_sub   <= (req_op_e == OP_SUB) || (req_op_e == OP_CMP);
                        alu_rst   <= (req_op_e == OP_CLR);
                    end
                end
                S_ISSUE: begin
                    state   <= S_WAIT;
                    alu_sum <= 1'b0;
                    alu_sub <= 1'b0;
                    alu_rst <= 1'b0;
                    alu_fi  <= 1'b1;
                end
                // Flags are passed through untouched; CMP only reports flags, so its data is zeroed.
                S_WAIT: begin
                    if (wait_last) begin
                        state     <= S_RESP;
                        rsp_data  <= (op_q == OP_CMP) ? '0 : alu_out;
                        rsp_carry <= alu_carry;
                        rsp_zero  <= alu_zero;
                        rsp_op    <= op_q;
                        rsp_valid <= 1'b1;
                        alu_fi    <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                // Unreachable encodings recover through INIT so the alu is cleared again.
                default: begin
                    state     <= S_INIT;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b1;
                    alu_rst   <= 1'b1;
                    alu_sum   <= 1'b0;
                    alu_sub   <= 1'b0;
                    alu_fi    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer driving a behavioural 3-cycle alu.
// Latency: n/a.
// Backpressure: exercised with rsp_ready held low across a response.
module tb_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_op;
    logic [W-1:0] rsp_data;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         busy;
    logic         alu_rst;
    logic         alu_sum;
    logic         alu_sub;
    logic         alu_fi;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic         alu_carry;
    logic         alu_zero;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.WIDTH(W), .LAT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op    (rsp_op),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .busy      (busy),
        .alu_rst   (alu_rst),
        .alu_sum   (alu_sum),
        .alu_sub   (alu_sub),
        .alu_fi    (alu_fi),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural alu: result registered on the strobe edge, then two more stages; flags only under alu_fi.
    logic [W:0] add_r, sub_r;
    logic [W:0] s0, s1, s2;
    logic       z0, z1, z2;
    assign add_r = {1'b0, alu_a} + {1'b0, alu_b};
    assign sub_r = {1'b0, alu_a} - {1'b0, alu_b};

    always @(posedge clk) begin
        if (alu_rst) begin
            s0 <= '0; s1 <= '0; s2 <= '0;
            z0 <= 1'b0; z1 <= 1'b0; z2 <= 1'b0;
        end else begin
            if (alu_sum) begin
                s0 <= add_r;
                z0 <= (add_r[W-1:0] == '0);
            end else if (alu_sub) begin
                s0 <= sub_r;
                z0 <= (sub_r[W-1:0] == '0);
            end
            s1 <= s0; z1 <= z0;
            s2 <= s1; z2 <= z1;
        end
    end

    assign alu_out   = s2[W-1:0];
    assign alu_carry = alu_fi & s2[W];
    assign alu_zero  = alu_fi & z2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // One complete op with rsp_ready high: latency, strobes, wait window, operands and response.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] strb,
                          input logic [W-1:0] data, input logic carry, input logic zero);
        int       lat;
        int       fi_cnt;
        int       strb_tot;
        logic [2:0] strb_seen;
        logic     ops_ok;
        logic     busy_ok;
        wait_ready(tag);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = ~op; req_a = ~a; req_b = 8'h5A;
        lat = -1; fi_cnt = 0; strb_tot = 0; strb_seen = '0; ops_ok = 1'b1; busy_ok = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k - 1;
                break;
            end
            strb_seen = strb_seen | {alu_sum, alu_sub, alu_rst};
            strb_tot  = strb_tot + int'(alu_sum) + int'(alu_sub) + int'(alu_rst);
            fi_cnt    = fi_cnt + int'(alu_fi);
            if (alu_a !== a || alu_b !== b) ops_ok = 1'b0;
            if (!busy || req_ready) busy_ok = 1'b0;
        end
        chk({tag, " latency"},    32'(lat),       32'd4);
        chk({tag, " strobe"},     32'(strb_seen), 32'(strb));
        chk({tag, " strobe_cnt"}, 32'(strb_tot),  32'd1);
        chk({tag, " fi_cycles"},  32'(fi_cnt),    32'd3);
        chk({tag, " operands"},   32'(ops_ok),    32'd1);
        chk({tag, " busy"},       32'(busy_ok),   32'd1);
        chk({tag, " data"},       32'(rsp_data),  32'(data));
        chk({tag, " carry"},      32'(rsp_carry), 32'(carry));
        chk({tag, " zero"},       32'(rsp_zero),  32'(zero));
        chk({tag, " op"},         32'(rsp_op),    32'(op));
        @(posedge clk);
        @(negedge clk);
        chk({tag, " valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle_busy"},  32'(busy),      32'd0);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   strb;   // {alu_sum, alu_sub, alu_rst}
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        logic accepted;
        logic no_rsp;

        vecs[0] = '{2'd0, 8'd200, 8'd100, 3'b100, 8'h2C, 1'b1, 1'b0};
        vecs[1] = '{2'd1, 8'd3,   8'd5,   3'b010, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{2'd2, 8'd9,   8'd9,   3'b010, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{2'd0, 8'h80,  8'h80,  3'b100, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{2'd1, 8'd10,  8'd4,   3'b010, 8'h06, 1'b0, 1'b0};
        vecs[5] = '{2'd0, 8'd1,   8'd2,   3'b100, 8'h03, 1'b0, 1'b0};
        vecs[6] = '{2'd3, 8'h55,  8'hAA,  3'b001, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{2'd2, 8'd5,   8'd7,   3'b010, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{2'd0, 8'hFF,  8'h01,  3'b100, 8'h00, 1'b1, 1'b1};
        vecs[9] = '{2'd1, 8'd7,   8'd7,   3'b010, 8'h00, 1'b0, 1'b1};

        rst = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

        // Reset and INIT
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst alu_rst", 32'(alu_rst), 32'd1);
        chk("rst busy",    32'(busy),    32'd1);
        chk("rst ctrl",    32'({req_ready, rsp_valid, alu_sum, alu_sub, alu_fi}), 32'd0);
        chk("rst data",    32'({rsp_data, rsp_carry, rsp_zero, rsp_op}), 32'd0);
        chk("rst operands", 32'({alu_a, alu_b}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("init alu_rst",   32'(alu_rst),   32'd1);
        chk("init req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("idle alu_rst",   32'(alu_rst),   32'd0);
        chk("idle req_ready", 32'(req_ready), 32'd1);
        chk("idle busy",      32'(busy),      32'd0);
        chk("idle rsp",       32'({rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_op}), 32'd0);

        // Table of single ops with the response side always ready
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].strb,
                   vecs[i].data, vecs[i].carry, vecs[i].zero);
        end

        // Backpressure: response held for 10 cycles, requests during RESP dropped
        rsp_ready = 1'b0;
        wait_ready("bp");
        req_op = 2'd0; req_a = 8'd1; req_b = 8'd2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
        stable = 1'b1; accepted = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 8'd3 || rsp_op !== 2'd0) stable = 1'b0;
            if (req_ready || alu_sum || alu_sub || alu_rst) accepted = 1'b1;
            req_valid = (k % 2 == 1);
            req_op = 2'd3; req_a = 8'hEE; req_b = 8'h11;
        end
        req_valid = 1'b0;
        chk("bp stable",   32'(stable),   32'd1);
        chk("bp no_accept", 32'(accepted), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp handshake", 32'(rsp_valid), 32'd0);
        chk("bp idle",      32'(busy),      32'd0);
        @(negedge clk);
        chk("bp single", 32'({rsp_valid, alu_sum, alu_sub, alu_rst}), 32'd0);

        // Reset asserted during WAIT
        wait_ready("mid");
        req_op = 2'd0; req_a = 8'd200; req_b = 8'd100; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid fi_before", 32'(alu_fi), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid fi",       32'(alu_fi),    32'd0);
        chk("mid busy",     32'(busy),      32'd1);
        chk("mid rsp",      32'(rsp_valid), 32'd0);
        chk("mid alu_rst",  32'(alu_rst),   32'd1);
        chk("mid operands", 32'({alu_a, alu_b}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        no_rsp = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) no_rsp = 1'b0;
        end
        chk("mid discarded", 32'(no_rsp), 32'd1);
        run_op("post", 2'd0, 8'd1, 8'd1, 3'b100, 8'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side driver for the `alu` block.
- Accepts operation requests on a valid/ready interface and drives `alu` control and operand inputs with the timing `alu` requires.
- Waits out the `alu` pipeline latency, then captures result and flags.
- Returns them on a valid/ready response interface.
- Sits between the control path and one `alu` instance; it is the only source of `alu` control strobes.

Parameters:
- WIDTH, 8, operand/result width; must match the `alu` instance.
- LAT, 3, cycles from issue cycle to capture edge; minimum 3.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request valid.
- req_ready, output, 1, request accepted when req_valid and req_ready are both 1 at a clk edge.
- req_op, input, 2, operation: 0 ADD, 1 SUB, 2 CMP, 3 CLR.
- req_a, input, WIDTH, operand A.
- req_b, input, WIDTH, operand B.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, response consumed when rsp_valid and rsp_ready are both 1 at a clk edge.
- rsp_op, output, 2, opcode of the returned response.
- rsp_data, output, WIDTH, result.
- rsp_carry, output, 1, captured carry.
- rsp_zero, output, 1, captured zero.
- busy, output, 1, high in every state except IDLE.
- alu_rst, output, 1, `alu` synchronous active-high reset.
- alu_sum, output, 1, `alu` add strobe.
- alu_sub, output, 1, `alu` subtract strobe.
- alu_fi, output, 1, `alu` flag-output enable.
- alu_a, output, WIDTH, `alu` operand A.
- alu_b, output, WIDTH, `alu` operand B.
- alu_out, input, WIDTH, `alu` result.
- alu_carry, input, 1, `alu` carry flag.
- alu_zero, input, 1, `alu` zero flag.

Behaviour:
- Reset values (rst low):
  - state INIT.
  - alu_rst 1.
  - req_ready, rsp_valid, alu_sum, alu_sub, alu_fi 0.
  - rsp_data, rsp_carry, rsp_zero, rsp_op, alu_a, alu_b 0.
  - busy 1.
- All outputs are registered. No combinational path from any input to any output.
- States: INIT, IDLE, ISSUE, WAIT, RESP.
- INIT:
  - One cycle after rst deasserts, with alu_rst=1 so the `alu` clears.
  - Then go to IDLE with alu_rst=0.
- IDLE:
  - req_ready=1 in this state only.
  - On accept, latch op, a and b (alu_a/alu_b hold the latched operands), then go to ISSUE.
  - busy rises on the edge after accept.
- ISSUE (exactly one cycle):
  - ADD: alu_sum=1.
  - SUB and CMP: alu_sub=1.
  - CLR: alu_rst=1.
  - Only one of alu_sum, alu_sub, alu_rst is ever high in a given cycle.
- WAIT:
  - LAT cycles, counted by a down-counter loaded with LAT at ISSUE exit.
  - alu_fi=1 throughout WAIT for every op.
  - Strobes stay low; alu_a/alu_b stay stable.
- Capture, on the edge that ends the last WAIT cycle:
  - rsp_data <= alu_out; forced to 0 for CMP.
  - rsp_carry <= alu_carry.
  - rsp_zero <= alu_zero.
  - rsp_op <= latched op.
  - rsp_valid <= 1.
  - alu_fi <= 0.
  - Go to RESP.
- RESP:
  - rsp_* held stable while rsp_ready=0; no timeout.
  - On handshake: rsp_valid <= 0, go to IDLE.
  - The next request can be accepted on the following cycle, so there is one bubble cycle between back-to-back ops.
- Throughput: one op per LAT+3 cycles. Latency from accept edge to rsp_valid high is LAT+1 edges.
- Flags are forwarded verbatim. The sequencer does not compute or correct carry or zero.
- Boundary conditions:
  - req_valid while busy: ignored, not queued.
  - req_op, req_a, req_b changing after accept: no effect.
  - rsp_ready high outside RESP: ignored.
  - rst asserted mid-operation: all outputs take their reset values immediately, and the in-flight op and pending response are discarded. After rst deasserts, INIT clears the `alu` again.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t, 2-bit enum ADD/SUB/CMP/CLR.
  - typedef seq_state_t enum.
  - constant ALU_MIN_LAT=3.
- Sub-module: none required. An optional lat_counter (loadable down-counter with done flag) is natural if reused.

Test Plan:
- Scenarios run against a real `alu` (WIDTH=8, LAT=3) unless noted.
- Reset: hold rst=0 for 3 cycles, then release → alu_rst=1 for exactly one cycle, then req_ready=1, busy=0, all rsp_* 0.
- ADD a=200, b=100, rsp_ready=1 → alu_sum high exactly one cycle; rsp_valid rises 4 edges after accept; rsp_data=0x2C, rsp_carry=1, rsp_op=0.
- SUB a=3, b=5, then CMP a=9, b=9:
  - SUB → rsp_data=0xFE, rsp_carry=1.
  - CMP → rsp_data=0x00, rsp_op=2, alu_sub high one cycle.
- Backpressure: ADD 1+2 with rsp_ready=0 for 10 cycles → rsp_valid and rsp_data=3 stable all 10 cycles; req_valid pulses during this time not accepted; single handshake when rsp_ready=1.
- CLR after an ADD → alu_rst high one cycle in ISSUE; rsp_data=0, rsp_carry=0, rsp_zero=0, rsp_op=3.
- Reset mid-op: assert rst during WAIT of ADD 200+100 → alu_fi, busy and rsp_valid drop asynchronously to reset values; no response appears after release; the next ADD 1+1 returns 2.
